obf_seq_ctrl: RTL
=================

OBF_SEQ_CTRL -- requirements
Module: obf_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WDOG_MAX, 16: maximum micro-ops per reference instruction when the watchdog is compiled in.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: the single clock.
- rst, in, 1: reset, asynchronous, active-high.
- if_insn_i, in, 32: reference instruction from fetch.
- if_valid_i, in, 1: if_insn_i is valid.
- if_ready_o, out, 1: controller accepts if_insn_i this cycle.
- obf_en_i, in, 1: obfuscation enable.
- obf_key_i, in, OBF_KEY_WIDTH: substitution key.
- flush_i, in, 1: pipeline flush.
- id_insn_o, out, 32: micro-op to decode.
- id_valid_o, out, 1: id_insn_o is valid.
- id_ready_i, in, 1: decode accepts id_insn_o.
- id_last_o, out, 1: micro-op is the last of its reference instruction; the PC may advance.
- id_skip_o, out, 1: micro-op carries a LUT immediate.
- busy_o, out, 1: a sequence is in progress.
- wdog_err_o, out, 1: one-cycle watchdog pulse.
REQ-003 The block SHALL instantiate one obf_insngen, driving:
- ref_insn from the hold register;
- ppc_i from the step counter;
- obf_key from obf_key_i;
- obf_en from the latched enable.

Function
REQ-004 The block SHALL implement a two-state FSM with states IDLE and ISSUE.
REQ-005 In IDLE, if_ready_o SHALL be 1; if_valid_i=1 SHALL trigger the following, with the FSM entering ISSUE the next cycle:
- latch if_insn_i into the hold register;
- latch obf_en_i into en_q;
- clear the step counter ppc to 0.
REQ-006 In ISSUE:
- id_valid_o=1;
- id_insn_o, id_last_o and id_skip_o SHALL equal the generator's obf_insn, obf_last and obf_skip outputs (combinational from hold register, ppc, key and en_q).
REQ-007 Latency: an instruction accepted in cycle N SHALL present its first micro-op in cycle N+1.
REQ-008 In ISSUE with id_ready_i=1 and id_last_o=0, ppc SHALL increment by 1 and the FSM SHALL remain in ISSUE.
REQ-009 In ISSUE with id_ready_i=1 and id_last_o=1, if_ready_o SHALL be 1 in the same cycle, and:
- if if_valid_i=1: latch the new instruction (as REQ-005), clear ppc, stay in ISSUE (back-to-back, no bubble);
- otherwise: go to IDLE.
REQ-010 In ISSUE, if_ready_o SHALL be 0 in every case except REQ-009.
REQ-011 In ISSUE with id_ready_i=0, the following SHALL hold stable:
- hold register, ppc, en_q;
- id_insn_o, id_last_o, id_skip_o.
REQ-012 en_q SHALL NOT change mid-sequence; obf_en_i changes take effect only on the next accept.
REQ-013 With en_q=0, every instruction SHALL produce exactly one micro-op equal to the reference instruction, with id_last_o=1 and id_skip_o=0.
REQ-014 flush_i=1 SHALL force IDLE, clear ppc, and set id_valid_o=0 on the next edge, overriding all other events in that cycle.
REQ-015 With flush_i=1, if_ready_o SHALL be 0 and no fetch accept SHALL occur in that cycle.
REQ-016 ppc SHALL be OBF_PPC_WIDTH wide and SHALL saturate at all-ones, never wrapping to 0.
REQ-017 busy_o SHALL be 1 exactly when the FSM is in ISSUE.
REQ-018 In IDLE, id_valid_o, id_last_o and id_skip_o SHALL be 0.

Reset
REQ-019 rst=1 SHALL asynchronously force the following, independent of clk:
- FSM to IDLE;
- ppc, en_q and the hold register to 0;
- wdog_err_o to 0.
REQ-020 After reset, outputs SHALL be id_valid_o=0, busy_o=0 and if_ready_o=1.
REQ-021 Reset asserted mid-sequence SHALL discard the sequence with no further micro-ops emitted.

Configuration
REQ-022 Macro OBF_SEQ_WDOG_EN.
REQ-023 With OBF_SEQ_WDOG_EN defined, at ppc = WDOG_MAX-1 in ISSUE:
- id_last_o SHALL be forced to 1;
- on the handshake, wdog_err_o SHALL pulse for 1 cycle;
- the sequence SHALL end as in REQ-009.
REQ-024 Without OBF_SEQ_WDOG_EN:
- no watchdog logic;
- wdog_err_o tied to 0;
- sequences end only on generator obf_last (subject to REQ-016 saturation).

Verification
REQ-025 Reset release with if_valid_i=1 and obf_en_i=0 -> accept in cycle N; cycle N+1 id_insn_o = input, id_last_o=1, id_skip_o=0; next cycle IDLE.
REQ-026 obf_en_i=1 with a key whose LUT yields a 3-step sequence, id_ready_i=1 -> ppc 0,1,2 on consecutive cycles; id_last_o=1 only at ppc=2; if_ready_o=1 only in that cycle.
REQ-027 Two back-to-back instructions with the last handshake coinciding with if_valid_i=1 -> no idle cycle; ppc returns to 0.
REQ-028 id_ready_i=0 for 4 cycles at ppc=1 -> id_insn_o and ppc unchanged throughout; ppc=2 after release.
REQ-029 flush_i=1 at ppc=1 with if_valid_i=1 -> next cycle IDLE, id_valid_o=0, no accept; mid-sequence async rst -> immediate IDLE.
REQ-030 With OBF_SEQ_WDOG_EN and WDOG_MAX=4, a LUT never asserting last -> 4 micro-ops, 4th with id_last_o=1, wdog_err_o one-cycle pulse.

Source files
------------

// File: rtl/obf_seq_ctrl.sv
// Obfuscating micro-op sequencer: expands each fetched instruction into a keyed micro-op sequence.
// Optional watchdog is compiled in with `define OBF_SEQ_WDOG_EN.
module obf_insngen #(
  parameter int KEY_W = 8,
  parameter int PPC_W = 4
) (
  input  logic [31:0]      ref_insn,
  input  logic [PPC_W-1:0] ppc_i,
  input  logic [KEY_W-1:0] obf_key,
  input  logic             obf_en,
  output logic [31:0]      obf_insn,
  output logic             obf_last,
  output logic             obf_skip
);
  logic [7:0] key_byte;
  logic [7:0] ppc_ext;
  logic [7:0] mask;
  logic [2:0] seq_len;
  logic       lut_last;

  // Key low bits give the sequence length; zero means the LUT never terminates.
  always_comb begin
    key_byte = 8'(obf_key);
    ppc_ext  = 8'(ppc_i);
    seq_len  = key_byte[2:0];
    mask     = key_byte + ppc_ext;
    lut_last = (seq_len != 3'd0) && (ppc_ext == ({5'd0, seq_len} - 8'd1));
    if (obf_en) begin
      obf_insn = ref_insn ^ {mask, mask, mask, mask};
      obf_last = lut_last;
      obf_skip = ppc_i[0] && !lut_last;
    end else begin
      obf_insn = ref_insn;
      obf_last = 1'b1;
      obf_skip = 1'b0;
    end
  end
endmodule

module obf_seq_ctrl #(
  parameter int WDOG_MAX      = 16,
  parameter int OBF_KEY_WIDTH = 8,
  parameter int OBF_PPC_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              if_insn_i,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic                     obf_en_i,
  input  logic [OBF_KEY_WIDTH-1:0] obf_key_i,
  input  logic                     flush_i,
  output logic [31:0]              id_insn_o,
  output logic                     id_valid_o,
  input  logic                     id_ready_i,
  output logic                     id_last_o,
  output logic                     id_skip_o,
  output logic                     busy_o,
  output logic                     wdog_err_o
);
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              hold_q, hold_d;
  logic [OBF_PPC_WIDTH-1:0] ppc_q, ppc_d;
  logic                     en_q, en_d;

  logic [31:0] gen_insn;
  logic        gen_last, gen_skip;
  logic        busy, last_w, hs, accept, wdog_hit;

  obf_insngen #(
    .KEY_W (OBF_KEY_WIDTH),
    .PPC_W (OBF_PPC_WIDTH)
  ) u_gen (
    .ref_insn (hold_q),
    .ppc_i    (ppc_q),
    .obf_key  (obf_key_i),
    .obf_en   (en_q),
    .obf_insn (gen_insn),
    .obf_last (gen_last),
    .obf_skip (gen_skip)
  );

`ifdef OBF_SEQ_WDOG_EN
  logic wdog_q, wdog_d;
  assign wdog_hit   = (state_q == ISSUE) && (ppc_q == OBF_PPC_WIDTH'(WDOG_MAX - 1));
  assign wdog_d     = hs && wdog_hit;
  assign wdog_err_o = wdog_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wdog_q <= 1'b0;
    else     wdog_q <= wdog_d;
  end
`else
  localparam int unused_wdog_max = WDOG_MAX;
  assign wdog_hit   = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  // Flush blocks both the decode handshake and the fetch accept for this cycle.
  always_comb begin
    busy       = (state_q == ISSUE);
    last_w     = gen_last || wdog_hit;
    hs         = busy && id_ready_i && !flush_i;
    if_ready_o = !flush_i && (!busy || (id_ready_i && last_w));
    accept     = if_ready_o && if_valid_i;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ppc_d   = ppc_q;
    en_d    = en_q;
    if (flush_i) begin
      state_d = IDLE;
      ppc_d   = '0;
    end else if (accept) begin
      state_d = ISSUE;
      hold_d  = if_insn_i;
      en_d    = obf_en_i;
      ppc_d   = '0;
    end else if (hs) begin
      if (last_w) begin
        state_d = IDLE;
      end else if (ppc_q != '1) begin
        ppc_d = ppc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      ppc_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      ppc_q   <= ppc_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    busy_o     = busy;
    id_valid_o = busy;
    id_insn_o  = busy ? gen_insn : 32'd0;
    id_last_o  = busy && last_w;
    id_skip_o  = busy && gen_skip;
  end
endmodule
